gestor_solicitudes: RTL and testbench

- Request side of the elevator controller: debounces the per-floor call buttons, latches pending calls, and chooses the next target floor with a SCAN (elevator) policy.
- Drives the 4-bit `memoria` request code consumed by `maquina_estados`.
- Closes the loop by watching the FSM's `piso`/`accion`/`puertas` outputs to retire calls once served.

---
 rtl/ascensor_pkg.sv | 24 ++
 rtl/antirrebote.sv | 31 +++
 rtl/gestor_solicitudes.sv | 138 +++++++++++++
 tb/tb_gestor_solicitudes.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ascensor_pkg.sv
// Shared definitions for the elevator controller: motion codes, request
// encoding and the selection result record.
package ascensor_pkg;

  localparam int N_PISOS = 4;

  localparam logic [1:0] ACC_PARADO = 2'b00;
  localparam logic [1:0] ACC_SUBE   = 2'b01;
  localparam logic [1:0] ACC_BAJA   = 2'b10;

  localparam logic [3:0] MEM_NADA = 4'd0;

  // Result of the SCAN choice: request code plus the direction to keep.
  typedef struct packed {
    logic [3:0] memoria;
    logic       direccion;
  } seleccion_t;

  // Floor number to request code (0 is reserved for "no request").
  function automatic logic [3:0] piso_a_memoria(input logic [1:0] f);
    return {2'b00, f} + 4'd1;
  endfunction

endpackage

// File: rtl/antirrebote.sv
// Single-button debouncer: saturating run-length counter with a one-shot
// accept pulse the cycle the run reaches DEB_CICLOS.
module antirrebote #(
  parameter int DEB_CICLOS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic boton,
  output logic acepta
);

  localparam logic [3:0] DEB_MAX = 4'(DEB_CICLOS);

  logic [3:0] cnt_q, cnt_d;

  // Count consecutive high cycles, hold at DEB_MAX, clear on release.
  always_comb begin
    cnt_d = '0;
    if (boton) cnt_d = (cnt_q == DEB_MAX) ? DEB_MAX : cnt_q + 4'd1;
  end

  // Fires only on the transition into DEB_MAX, so a held button yields one pulse.
  assign acepta = boton && (cnt_q == DEB_MAX - 4'd1);

  // Counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/gestor_solicitudes.sv
// Request side of the elevator: debounced call latching, SCAN target choice
// and the registered request code consumed by the motion FSM.
module gestor_solicitudes
  import ascensor_pkg::*;
#(
  parameter int DEB_CICLOS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [N_PISOS-1:0] botones,
  input  logic [1:0]         piso,
  input  logic [1:0]         accion,
  input  logic               puertas,
  output logic [3:0]         memoria,
  output logic [N_PISOS-1:0] pendientes,
  output logic               direccion
);

  logic [N_PISOS-1:0] acepta;
  logic [N_PISOS-1:0] servicio;
  logic [N_PISOS-1:0] pend_q, pend_d;
  logic [3:0]         mem_q, mem_d;
  logic               dir_q;
  seleccion_t         sel;

  for (genvar f = 0; f < N_PISOS; f++) begin : g_deb
    antirrebote #(.DEB_CICLOS(DEB_CICLOS)) u_deb (
      .clk    (clk),
      .rst    (rst),
      .boton  (botones[f]),
      .acepta (acepta[f])
    );
  end

  // A call is served when the car sits at that floor, stopped, doors open.
  always_comb begin
    servicio = '0;
    for (int f = 0; f < N_PISOS; f++)
      servicio[f] = (int'(piso) == f) && (accion == ACC_PARADO) && puertas;
  end

  // Latch accepted calls; service wins over a same-cycle accept.
  always_comb begin
    pend_d = (pend_q | acepta) & ~servicio;
  end

  // SCAN choice from the latched calls and the current direction.
  logic       hay_arriba, hay_abajo;
  logic [3:0] cand_arriba, cand_abajo;
  always_comb begin
    hay_arriba  = 1'b0;
    hay_abajo   = 1'b0;
    cand_arriba = MEM_NADA;
    cand_abajo  = MEM_NADA;
    // Walk downward so the last hit above is the closest one.
    for (int f = N_PISOS - 1; f >= 0; f--) begin
      if (pend_q[f] && f > int'(piso)) begin
        hay_arriba  = 1'b1;
        cand_arriba = piso_a_memoria(2'(f));
      end
    end
    // Walk upward so the last hit below is the closest one.
    for (int f = 0; f < N_PISOS; f++) begin
      if (pend_q[f] && f < int'(piso)) begin
        hay_abajo  = 1'b1;
        cand_abajo = piso_a_memoria(2'(f));
      end
    end

    sel.memoria   = MEM_NADA;
    sel.direccion = dir_q;
    if (pend_q[piso]) begin
      sel.memoria = piso_a_memoria(piso);
    end else if (dir_q) begin
      if (hay_arriba) begin
        sel.memoria = cand_arriba;
      end else if (hay_abajo) begin
        sel.memoria   = cand_abajo;
        sel.direccion = 1'b0;
      end
    end else begin
      if (hay_abajo) begin
        sel.memoria = cand_abajo;
      end else if (hay_arriba) begin
        sel.memoria   = cand_arriba;
        sel.direccion = 1'b1;
      end
    end
  end

  // Request code update: follow the choice when stopped, only shorten the
  // trip when moving, drop the target once its call has been retired.
  logic [3:0] mem_m1;
  logic [1:0] piso_obj;
  logic [3:0] piso_m;
  logic       entre;
  always_comb begin
    mem_m1   = mem_q - 4'd1;
    piso_obj = mem_m1[1:0];
    piso_m   = piso_a_memoria(piso);
    entre    = 1'b0;
    if (accion == ACC_SUBE)
      entre = (sel.memoria > piso_m) && (sel.memoria < mem_q);
    else if (accion == ACC_BAJA)
      entre = (sel.memoria < piso_m) && (sel.memoria > mem_q);

    mem_d = mem_q;
    if (!en) begin
      mem_d = MEM_NADA;
    end else if (accion == ACC_SUBE || accion == ACC_BAJA) begin
      // With no target yet, moving is treated like idle and takes the choice.
      if (mem_q == MEM_NADA)                     mem_d = sel.memoria;
      else if (!pend_q[piso_obj])                mem_d = MEM_NADA;
      else if (sel.memoria != MEM_NADA && entre) mem_d = sel.memoria;
    end else begin
      mem_d = sel.memoria;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q <= '0;
      mem_q  <= MEM_NADA;
      dir_q  <= 1'b1;
    end else begin
      pend_q <= pend_d;
      mem_q  <= mem_d;
      dir_q  <= sel.direccion;
    end
  end

  assign memoria    = mem_q;
  assign pendientes = pend_q;
  assign direccion  = dir_q;

endmodule

// File: tb/tb_gestor_solicitudes.sv
// Directed bench for gestor_solicitudes: a per-cycle vector table plus
// hand-written multi-cycle sequences.
module tb_gestor_solicitudes;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] botones;
  logic [1:0] piso;
  logic [1:0] accion;
  logic       puertas;
  logic [3:0] memoria;
  logic [3:0] pendientes;
  logic       direccion;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gestor_solicitudes #(.DEB_CICLOS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .botones    (botones),
    .piso       (piso),
    .accion     (accion),
    .puertas    (puertas),
    .memoria    (memoria),
    .pendientes (pendientes),
    .direccion  (direccion)
  );

  typedef struct {
    logic [3:0] bot;
    logic [1:0] piso;
    logic [1:0] acc;
    logic       pue;
    logic       en;
    logic [3:0] mem;
    logic [3:0] pend;
    logic       dir;
  } vec_t;

  vec_t tabla [16];

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] esp);
    checks++;
    if (act !== esp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, esp);
    end
  endtask

  task automatic ciclo;
    @(negedge clk);
  endtask

  task automatic reset_dut;
    rst = 1'b0; en = 1'b1; botones = '0; piso = '0; accion = 2'b00; puertas = 1'b0;
    ciclo();
    rst = 1'b1;
  endtask

  initial begin
    // Each row is applied across one rising edge; expectations are after it.
    tabla[0]  = '{4'b0100, 2'd1, 2'b00, 1'b0, 1'b1, 4'd0, 4'b0000, 1'b1};
    tabla[1]  = '{4'b0100, 2'd1, 2'b00, 1'b0, 1'b1, 4'd0, 4'b0000, 1'b1};
    tabla[2]  = '{4'b0100, 2'd1, 2'b00, 1'b0, 1'b1, 4'd0, 4'b0000, 1'b1};
    tabla[3]  = '{4'b0000, 2'd1, 2'b00, 1'b0, 1'b1, 4'd0, 4'b0000, 1'b1};
    tabla[4]  = '{4'b0101, 2'd1, 2'b00, 1'b0, 1'b1, 4'd0, 4'b0000, 1'b1};
    tabla[5]  = '{4'b0101, 2'd1, 2'b00, 1'b0, 1'b1, 4'd0, 4'b0000, 1'b1};
    tabla[6]  = '{4'b0101, 2'd1, 2'b00, 1'b0, 1'b1, 4'd0, 4'b0000, 1'b1};
    tabla[7]  = '{4'b0101, 2'd1, 2'b00, 1'b0, 1'b1, 4'd0, 4'b0101, 1'b1};
    tabla[8]  = '{4'b0000, 2'd1, 2'b00, 1'b0, 1'b1, 4'd3, 4'b0101, 1'b1};
    tabla[9]  = '{4'b0000, 2'd2, 2'b00, 1'b1, 1'b1, 4'd3, 4'b0001, 1'b1};
    tabla[10] = '{4'b0000, 2'd2, 2'b00, 1'b0, 1'b1, 4'd1, 4'b0001, 1'b0};
    tabla[11] = '{4'b0000, 2'd2, 2'b00, 1'b0, 1'b0, 4'd0, 4'b0001, 1'b0};
    tabla[12] = '{4'b0000, 2'd2, 2'b00, 1'b0, 1'b1, 4'd1, 4'b0001, 1'b0};
    tabla[13] = '{4'b0000, 2'd0, 2'b00, 1'b0, 1'b1, 4'd1, 4'b0001, 1'b0};
    tabla[14] = '{4'b0000, 2'd0, 2'b00, 1'b1, 1'b1, 4'd1, 4'b0000, 1'b0};
    tabla[15] = '{4'b0000, 2'd0, 2'b00, 1'b0, 1'b1, 4'd0, 4'b0000, 1'b0};

    // Power-on reset, checked without any clock edge.
    rst = 1'b1; en = 1'b1; botones = '0; piso = '0; accion = 2'b00; puertas = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("rst_mem", memoria, 4'd0);
    chk("rst_pend", pendientes, 4'b0000);
    chk("rst_dir", {3'b0, direccion}, 4'd1);
    ciclo();
    rst = 1'b1;

    for (int i = 0; i < 16; i++) begin
      botones = tabla[i].bot; piso = tabla[i].piso; accion = tabla[i].acc;
      puertas = tabla[i].pue; en = tabla[i].en;
      ciclo();
      chk($sformatf("tab%0d_mem", i), memoria, tabla[i].mem);
      chk($sformatf("tab%0d_pend", i), pendientes, tabla[i].pend);
      chk($sformatf("tab%0d_dir", i), {3'b0, direccion}, {3'b0, tabla[i].dir});
    end

    // Held button: one accept only, even after the call is served mid-hold.
    reset_dut();
    botones = 4'b0010;
    repeat (4) ciclo();
    chk("held_accept", pendientes, 4'b0010);
    piso = 2'd1; puertas = 1'b1;
    ciclo();
    chk("held_served", pendientes, 4'b0000);
    piso = 2'd0; puertas = 1'b0;
    repeat (15) ciclo();
    chk("held20_single", pendientes, 4'b0000);
    botones = '0;
    ciclo();

    // Moving up toward floor 3, a call at floor 2 is on the way.
    reset_dut();
    piso = 2'd1; botones = 4'b1000;
    repeat (4) ciclo();
    botones = '0;
    ciclo();
    chk("mov_setup_mem", memoria, 4'd4);
    accion = 2'b01; botones = 4'b0100;
    repeat (4) ciclo();
    chk("mov_pend", pendientes, 4'b1100);
    chk("mov_hold", memoria, 4'd4);
    botones = '0;
    ciclo();
    chk("mov_retarget", memoria, 4'd3);

    // Moving up toward floor 3, a call behind the car does not retarget.
    reset_dut();
    piso = 2'd1; botones = 4'b1000;
    repeat (4) ciclo();
    botones = '0;
    ciclo();
    accion = 2'b01; botones = 4'b0001;
    repeat (4) ciclo();
    botones = '0;
    ciclo();
    chk("behind_pend", pendientes, 4'b1001);
    chk("behind_mem", memoria, 4'd4);
    chk("behind_dir", {3'b0, direccion}, 4'd1);
    ciclo();
    chk("behind_mem2", memoria, 4'd4);

    // Accept and service of the same floor in the same cycle.
    reset_dut();
    piso = 2'd2; botones = 4'b0001;
    repeat (4) ciclo();
    botones = '0;
    ciclo();
    chk("sim_setup_mem", memoria, 4'd1);
    chk("sim_setup_dir", {3'b0, direccion}, 4'd0);
    puertas = 1'b1; botones = 4'b0100;
    repeat (4) ciclo();
    chk("sim_pend", pendientes, 4'b0001);
    chk("sim_mem", memoria, 4'd1);
    botones = '0;
    ciclo();
    chk("sim_pend2", pendientes, 4'b0001);
    chk("sim_mem2", memoria, 4'd1);

    // Asynchronous reset mid-edge-interval with direction down.
    #2 rst = 1'b0;
    #1;
    chk("arst1_mem", memoria, 4'd0);
    chk("arst1_pend", pendientes, 4'b0000);
    chk("arst1_dir", {3'b0, direccion}, 4'd1);
    ciclo();
    rst = 1'b1; puertas = 1'b0;

    // Asynchronous reset with two pending calls and target floor 3.
    piso = 2'd2; botones = 4'b1010;
    repeat (4) ciclo();
    botones = '0;
    ciclo();
    chk("arst2_setup_pend", pendientes, 4'b1010);
    chk("arst2_setup_mem", memoria, 4'd4);
    #2 rst = 1'b0;
    #1;
    chk("arst2_mem", memoria, 4'd0);
    chk("arst2_pend", pendientes, 4'b0000);
    ciclo();
    rst = 1'b1;

    // Enable gating: memoria forced to 0, calls keep latching.
    piso = 2'd2; botones = 4'b1000;
    repeat (4) ciclo();
    botones = '0;
    ciclo();
    chk("en_setup_mem", memoria, 4'd4);
    en = 1'b0;
    ciclo();
    chk("en_off_mem", memoria, 4'd0);
    chk("en_off_pend", pendientes, 4'b1000);
    en = 1'b1;
    ciclo();
    chk("en_on_mem", memoria, 4'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
